spi_flash_ctrl: RTL and testbench
=================================

# spi_flash_ctrl

CPU-side SPI master for the configuration flash, mapped on the CPU IO bus. It owns the flash pins (`flash_cs`, `flash_clk`, `flash_si`, `flash_so`) and shares them with the JTAG SPI bridge, giving JTAG priority whenever the CPU is not holding chip-select. Firmware gets byte-wide mode-0 transfers with a programmable SCK divider. Status bits expose bus ownership and any dropped requests.

## Interface
Parameters:
- `DIV_RESET`, 1, reset value of the SCK divider (SCK = 48 MHz / (2·(DIV+1)))

Ports:
- `clk_48`  in  1  system clock; every register is clocked on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `io_addr_strobe`  in  1  IO bus transaction start
- `io_read_strobe`  in  1  read qualifier, valid with the address strobe
- `io_write_strobe`  in  1  write qualifier, valid with the address strobe
- `io_addr`  in  4  byte offset; bits [3:2] select the register
- `io_write_data`  in  32  write data
- `io_read_data`  out  32  read data, valid while `io_ready`=1
- `io_ready`  out  1  one-cycle transaction acknowledge
- `jtag_clk`, `jtag_cs_n`, `jtag_mosi`  in  1 each  from the JTAG bridge (asynchronous domain)
- `jtag_miso`  out  1  to the JTAG bridge
- `flash_cs`  out  1  flash chip-select, active low
- `flash_clk`  out  1  flash SCK
- `flash_si`  out  1  flash MOSI
- `flash_so`  in  1  flash MISO

## Operation
- Registers:
  - 0x0 CTRL/STAT. Write: bit0 `cs_hold` (1 asserts flash CS); any write also clears the sticky bits 3 and 4. Read: bit0 `cs_hold`, bit1 `busy`, bit2 `jtag_owner`, bit3 `dropped`, bit4 `jtag_denied`.
  - 0x4 DATA. Write: bits[7:0] start a byte transfer. Read: last received byte in bits[7:0].
  - 0x8 DIV. Bits[7:0], read/write.
  - 0xC: reads 0, writes ignored.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, JTAG.
- IDLE → SHIFT_LO on a DATA write.
  - `flash_si` is set to bit7 of the written byte.
  - `busy` is set in the same cycle as `io_ready`.
- SHIFT_LO → SHIFT_HI after DIV+1 cycles. SCK rises and `flash_so` is sampled into the rx shift register.
- SHIFT_HI → SHIFT_LO after DIV+1 cycles. SCK falls and the next bit is driven out.
- After the 8th falling edge, go to IDLE. `busy` clears and the rx byte is committed to DATA.
- Transfer order: SPI mode 0, MSB first.
- In IDLE and SHIFT states, `flash_cs` = !`cs_hold`.
- JTAG arbitration uses `jtag_cs_n` after a 2-FF synchronizer (`jcs_s`):
  - IDLE with `jcs_s`=0 and `cs_hold`=0 → JTAG.
  - In JTAG: `flash_cs`=`jtag_cs_n`, `flash_clk`=`jtag_clk`, `flash_si`=`jtag_mosi`, `jtag_miso`=`flash_so`. These are combinational pass-throughs of the raw inputs.
  - JTAG → IDLE when `jcs_s`=1.
- `jcs_s`=0 while `cs_hold`=1 or while a transfer is in progress:
  - JTAG is denied: `jtag_miso`=1 and the JTAG pins are not routed.
  - `jtag_denied` is set.
- Ignored requests set `dropped`:
  - A DATA write while `busy`=1 or while in JTAG is ignored.
  - A CTRL write of `cs_hold` while in JTAG is ignored; its sticky-clear still applies.
- A DIV write mid-transfer takes effect at the next half-period boundary.
- Reset values:
  - FSM = IDLE, `cs_hold`=0, DIV=`DIV_RESET`, rx=0x00, sticky bits 0.
  - `flash_cs`=1, `flash_clk`=0, `flash_si`=0.
  - `io_ready`=0, `io_read_data`=0, `jtag_miso`=1.
- Reset during a transfer aborts it immediately; pins take their reset values.

## Timing
- `io_ready` is a single-cycle pulse exactly one cycle after `io_addr_strobe`, for every offset including unmapped ones.
- `io_read_data` is 0 outside the ready cycle.
- Read data reflects register state sampled in the strobe cycle.
- A byte transfer takes 16·(DIV+1) cycles from the DATA-write ready cycle until `busy` clears. DIV=0 gives a 24 MHz SCK and 16 cycles.
- JTAG takeover happens 3 cycles after `jtag_cs_n` falls (2 synchronizer stages plus the FSM update). The release takes the same time.
- If the strobe of a DATA write lands in the same cycle as `jcs_s` falling in IDLE, the CPU wins and the FSM goes to SHIFT_LO.

## Configuration
- `SPI_FLASH_CTRL_JTAG_EN` defined: JTAG arbitration behaves as specified above.
- Undefined:
  - The synchronizer and the JTAG state are removed.
  - The JTAG inputs are ignored and `jtag_miso` is tied to 1.
  - STAT bits 2 and 4 read 0.

## Structure
- Package `spi_flash_pkg` holds:
  - register offsets
  - STAT bit positions
  - the FSM state enum
  - the 8-bit DIV width constant
- Sub-module `spi_byte_engine` contains the divider counter, SCK generation and the tx/rx shift registers. Its ports are start, byte in, byte out, done and DIV.
- Arbitration, register file and pin muxing stay in the top level.

## Test plan
- Reset, then read 0x0 and 0x8 → 0x00000000 and 0x00000001 (DIV_RESET=1), `io_ready` 1 cycle after each strobe; `flash_cs`=1, `flash_clk`=0.
- Write CTRL=1, then DATA=0x9F with DIV=0 and flash model returning 0xEF → MOSI bits 1001_1111, 8 SCK pulses, `busy` clears after 16 cycles, DATA reads 0xEF.
- DATA write while `busy` → byte ignored, STAT=0x0B (cs, busy, dropped); a CTRL write of 1 then gives STAT bit3=0.
- `cs_hold`=0, `jtag_cs_n` falls → `jtag_owner`=1 after 3 cycles, flash pins follow the JTAG inputs, DATA write sets `dropped`; `jtag_cs_n` rises → IDLE after 3 cycles.
- `cs_hold`=1, `jtag_cs_n` falls → `jtag_miso`=1, `flash_cs` stays low under CPU control, `jtag_denied`=1.
- Assert `rst` mid-transfer at DIV=3 → all outputs return to reset values asynchronously; next read of STAT = 0.

Source files
------------

// File: rtl/spi_flash_ctrl_pkg.sv
// spi_flash_pkg: shared constants for spi_flash_ctrl.
// Holds the register byte offsets, the STAT bit positions, the FSM state
// enum and the SCK divider width. No ports.
package spi_flash_pkg;
    localparam int DIV_W = 8;
    localparam logic [3:0] OFF_CTRL = 4'h0;
    localparam logic [3:0] OFF_DATA = 4'h4;
    localparam logic [3:0] OFF_DIV  = 4'h8;
    localparam int ST_CS_HOLD     = 0;
    localparam int ST_BUSY        = 1;
    localparam int ST_JTAG_OWNER  = 2;
    localparam int ST_DROPPED     = 3;
    localparam int ST_JTAG_DENIED = 4;
    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, JTAG} state_t;
endpackage

// File: rtl/spi_flash_ctrl_if.sv
// spi_flash_ctrl_if: CPU IO bus between the CPU (master) and spi_flash_ctrl (slave).
// Ports: addr_strobe/read_strobe/write_strobe start a transaction, addr is the
// byte offset, write_data the store data; read_data/ready come back one cycle later.
interface spi_flash_ctrl_if;
    logic        addr_strobe;
    logic        read_strobe;
    logic        write_strobe;
    logic [3:0]  addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    modport master (output addr_strobe, read_strobe, write_strobe, addr, write_data,
                    input read_data, ready);
    modport slave (input addr_strobe, read_strobe, write_strobe, addr, write_data,
                   output read_data, ready);
endinterface

// File: rtl/spi_flash_ctrl_byte_engine.sv
// spi_byte_engine: one mode-0, MSB-first SPI byte with a programmable half-period.
// Ports: clk_48/rst clock and async reset; start loads tx and begins; div sets the
// half-period to div+1 cycles; rx is the last committed byte; tick marks each
// half-period boundary; done pulses on the 8th falling edge; sck/mosi/miso are the pins.
module spi_byte_engine
    import spi_flash_pkg::*;
(
    input  logic             clk_48,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       tx,
    input  logic [DIV_W-1:0] div,
    input  logic             miso,
    output logic [7:0]       rx,
    output logic             done,
    output logic             tick,
    output logic             sck,
    output logic             mosi
);
    logic             run;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       bits;
    logic [7:0]       tx_sr;
    logic [7:0]       rx_sr;
    assign tick = run && cnt == div_q;
    assign done = tick && sck && bits == 3'd7;
    assign mosi = tx_sr[7];
    // div is re-latched at every half-period boundary so a mid-transfer
    // change never stretches or truncates the half-period in progress
    always_ff @(posedge clk_48 or posedge rst)
        if (rst) begin
            run   <= 1'b0;
            cnt   <= '0;
            div_q <= '0;
            bits  <= '0;
            tx_sr <= '0;
            rx_sr <= '0;
            rx    <= '0;
            sck   <= 1'b0;
        end else if (start) begin
            run   <= 1'b1;
            cnt   <= '0;
            div_q <= div;
            bits  <= '0;
            tx_sr <= tx;
            sck   <= 1'b0;
        end else if (tick) begin
            cnt   <= '0;
            div_q <= div;
            sck   <= !sck;
            if (!sck)
                rx_sr <= {rx_sr[6:0], miso};
            else begin
                bits  <= bits + 3'd1;
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
            if (done) begin
                run <= 1'b0;
                rx  <= rx_sr;
            end
        end else if (run)
            cnt <= cnt + 1'b1;
endmodule

// File: rtl/spi_flash_ctrl.sv
// spi_flash_ctrl: CPU SPI master for the configuration flash, shared with a JTAG SPI bridge.
// Ports: clk_48/rst clock and async reset; io CPU IO bus (slave); jtag_* from/to the
// JTAG bridge; flash_cs/flash_clk/flash_si/flash_so flash pins.
// Build option: define SPI_FLASH_CTRL_JTAG_EN to enable JTAG arbitration; otherwise
// the JTAG inputs are ignored, jtag_miso is 1 and STAT bits 2 and 4 read 0.
module spi_flash_ctrl
    import spi_flash_pkg::*;
#(
    parameter logic [DIV_W-1:0] DIV_RESET = 1
) (
    input  logic             clk_48,
    input  logic             rst,
    spi_flash_ctrl_if.slave  io,
    input  logic             jtag_clk,
    input  logic             jtag_cs_n,
    input  logic             jtag_mosi,
    output logic             jtag_miso,
    output logic             flash_cs,
    output logic             flash_clk,
    output logic             flash_si,
    input  logic             flash_so
);
    state_t           state;
    state_t           state_n;
    logic             cs_hold;
    logic             dropped;
    logic             denied;
    logic [DIV_W-1:0] div;
    logic             jcs_s;
    logic             busy;
    logic             owner;
    logic             wr;
    logic             rd;
    logic             wr_ctrl;
    logic             wr_data;
    logic             wr_div;
    logic             start;
    logic             drop;
    logic             deny;
    logic             tick;
    logic             done;
    logic             sck;
    logic             mosi;
    logic [7:0]       rx;
    logic [31:0]      stat;
    logic [31:0]      rdata;
    logic             unused;
    assign unused  = ^{io.addr[1:0], io.write_data[31:DIV_W]};
    assign wr      = io.addr_strobe && io.write_strobe;
    assign rd      = io.addr_strobe && io.read_strobe;
    assign wr_ctrl = wr && io.addr[3:2] == OFF_CTRL[3:2];
    assign wr_data = wr && io.addr[3:2] == OFF_DATA[3:2];
    assign wr_div  = wr && io.addr[3:2] == OFF_DIV[3:2];
    // a DATA write in IDLE always wins, even against a JTAG request in the same cycle
    assign start   = wr_data && state == IDLE;
    assign drop    = (wr_data && state != IDLE) || (wr_ctrl && owner);
    assign deny    = !jcs_s && (cs_hold || busy);
`ifdef SPI_FLASH_CTRL_JTAG_EN
    logic jcs_m;
    always_ff @(posedge clk_48 or posedge rst)
        if (rst)
            {jcs_s, jcs_m} <= 2'b11;
        else
            {jcs_s, jcs_m} <= {jcs_m, jtag_cs_n};
`else
    // a permanently idle JTAG request makes the JTAG state unreachable
    assign jcs_s = 1'b1;
`endif
    spi_byte_engine u_engine (
        .clk_48 (clk_48),
        .rst    (rst),
        .start  (start),
        .tx     (io.write_data[7:0]),
        .div    (div),
        .miso   (flash_so),
        .rx     (rx),
        .done   (done),
        .tick   (tick),
        .sck    (sck),
        .mosi   (mosi)
    );
    always_ff @(posedge clk_48 or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    always_comb begin
        state_n = state == IDLE     ? (start ? SHIFT_LO : (!jcs_s && !cs_hold) ? JTAG : IDLE) :
                  state == SHIFT_LO ? (tick ? SHIFT_HI : SHIFT_LO) :
                  state == SHIFT_HI ? (done ? IDLE : tick ? SHIFT_LO : SHIFT_HI) :
                                      (jcs_s ? IDLE : JTAG);
    end
    // JTAG ownership routes the raw bridge pins straight through
    always_comb begin
        busy      = state == SHIFT_LO || state == SHIFT_HI;
        owner     = state == JTAG;
        flash_cs  = owner ? jtag_cs_n : !cs_hold;
        flash_clk = owner ? jtag_clk : sck;
        flash_si  = owner ? jtag_mosi : mosi;
        jtag_miso = owner ? flash_so : 1'b1;
    end
    always_comb begin
        stat                 = '0;
        stat[ST_CS_HOLD]     = cs_hold;
        stat[ST_BUSY]        = busy;
        stat[ST_JTAG_OWNER]  = owner;
        stat[ST_DROPPED]     = dropped;
        stat[ST_JTAG_DENIED] = denied;
        rdata = io.addr[3:2] == OFF_CTRL[3:2] ? stat :
                io.addr[3:2] == OFF_DATA[3:2] ? {24'h0, rx} :
                io.addr[3:2] == OFF_DIV[3:2]  ? {{(32-DIV_W){1'b0}}, div} : '0;
    end
    // sticky bits: a CTRL write clears them, a new event in the same cycle still sets them
    always_ff @(posedge clk_48 or posedge rst)
        if (rst) begin
            cs_hold      <= 1'b0;
            dropped      <= 1'b0;
            denied       <= 1'b0;
            div          <= DIV_RESET;
            io.ready     <= 1'b0;
            io.read_data <= '0;
        end else begin
            io.ready     <= io.addr_strobe;
            io.read_data <= rd ? rdata : '0;
            if (wr_ctrl && !owner)
                cs_hold <= io.write_data[0];
            if (wr_div)
                div <= io.write_data[DIV_W-1:0];
            dropped <= (dropped && !wr_ctrl) || drop;
            denied  <= (denied && !wr_ctrl) || deny;
        end
endmodule

// File: tb/tb_spi_flash_ctrl.sv
// tb_spi_flash_ctrl: directed + randomized bench for spi_flash_ctrl with a serial flash model.
module tb_spi_flash_ctrl;
    logic clk_48 = 1'b0;
    logic rst = 1'b1;
    logic jtag_clk = 1'b0;
    logic jtag_cs_n = 1'b1;
    logic jtag_mosi = 1'b0;
    logic jtag_miso;
    logic flash_cs;
    logic flash_clk;
    logic flash_si;
    logic flash_so;
    int n_cmp = 0;
    int n_err = 0;

    spi_flash_ctrl_if io ();

    spi_flash_ctrl #(.DIV_RESET(8'd1)) dut (
        .clk_48    (clk_48),
        .rst       (rst),
        .io        (io),
        .jtag_clk  (jtag_clk),
        .jtag_cs_n (jtag_cs_n),
        .jtag_mosi (jtag_mosi),
        .jtag_miso (jtag_miso),
        .flash_cs  (flash_cs),
        .flash_clk (flash_clk),
        .flash_si  (flash_si),
        .flash_so  (flash_so)
    );

    always #5 clk_48 = !clk_48;

    // flash model: presents so_byte MSB first, one bit per SCK rise, and
    // collects MOSI bits on each rise
    int rises = 0;
    int falls = 0;
    int base = 0;
    logic [7:0] so_byte = 8'h00;
    logic [7:0] mosi_sh = 8'h00;
    longint t_fall = 0;
    longint t_rise1 = 0;
    logic so_ovr_en = 1'b0;
    logic so_ovr = 1'b0;
    logic [2:0] so_idx;
    assign so_idx = 3'(7 - (rises - base));
    assign flash_so = so_ovr_en ? so_ovr : so_byte[so_idx];
    always @(posedge flash_clk) begin
        rises = rises + 1;
        mosi_sh = {mosi_sh[6:0], flash_si};
        if (rises - base == 1) t_rise1 = $time;
    end
    always @(negedge flash_clk) begin
        falls = falls + 1;
        t_fall = $time;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic r, input logic w, input logic [3:0] a, input logic [31:0] d,
                       output logic [31:0] q, output longint t);
        @(negedge clk_48);
        io.addr_strobe = 1'b1;
        io.read_strobe = r;
        io.write_strobe = w;
        io.addr = a;
        io.write_data = d;
        @(negedge clk_48);
        t = $time;
        chk("ready", 32'(io.ready), 1);
        q = io.read_data;
        io.addr_strobe = 1'b0;
        io.read_strobe = 1'b0;
        io.write_strobe = 1'b0;
        @(negedge clk_48);
        chk("ready_pulse", 32'(io.ready), 0);
        chk("rdata_idle", io.read_data, 0);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] q;
        longint t;
        bus(1'b1, 1'b0, a, 32'h0, q, t);
        chk(tag, q, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, output longint t);
        logic [31:0] q;
        bus(1'b0, 1'b1, a, d, q, t);
    endtask

    // one full byte with cs_hold=1 already set; expectations come from the
    // mode-0 rules: first rise (dv+1) cycles and last fall 16(dv+1) cycles
    // after the ready cycle
    task automatic xfer(input logic [7:0] tx, input logic [7:0] rxb, input int dv);
        longint t;
        int fb;
        so_byte = rxb;
        base = rises;
        fb = falls;
        wr(4'h4, {24'h0, tx}, t);
        for (int i = 0; i < 1000 && falls - fb < 8; i++) @(negedge clk_48);
        chk("sck_falls", 32'(falls - fb), 8);
        chk("sck_rises", 32'(rises - base), 8);
        chk("mosi_byte", {24'h0, mosi_sh}, {24'h0, tx});
        chk("t_first_rise", 32'(t_rise1 - t), 32'((dv + 1) * 10 - 5));
        chk("t_busy", 32'(t_fall - t), 32'(160 * (dv + 1) - 5));
        repeat (4) @(negedge clk_48);
        chk("sck_quiet", 32'(rises - base), 8);
        rd_chk("stat_done", 4'h0, 32'h1);
        rd_chk("data_rx", 4'h4, {24'h0, rxb});
    endtask

    initial begin
        longint t;
        logic [7:0] a;
        logic [7:0] b;
        int dv;
        int fb;
        io.addr_strobe = 1'b0;
        io.read_strobe = 1'b0;
        io.write_strobe = 1'b0;
        io.addr = 4'h0;
        io.write_data = 32'h0;
        repeat (3) @(negedge clk_48);
        chk("rst_cs", 32'(flash_cs), 1);
        chk("rst_sck", 32'(flash_clk), 0);
        chk("rst_si", 32'(flash_si), 0);
        chk("rst_miso", 32'(jtag_miso), 1);
        chk("rst_ready", 32'(io.ready), 0);
        chk("rst_rdata", io.read_data, 0);
        rst = 1'b0;
        rd_chk("ctrl_reset", 4'h0, 32'h0);
        rd_chk("div_reset", 4'h8, 32'h1);
        rd_chk("data_reset", 4'h4, 32'h0);
        rd_chk("unmapped", 4'hC, 32'h0);
        wr(4'hC, 32'hFFFF_FFFF, t);
        rd_chk("unmapped_wr", 4'hC, 32'h0);
        wr(4'h0, 32'h1, t);
        chk("cs_hold_pin", 32'(flash_cs), 0);
        wr(4'h8, 32'h0, t);
        rd_chk("div0", 4'h8, 32'h0);
        xfer(8'h9F, 8'hEF, 0);
        repeat (5) begin
            dv = int'($urandom_range(0, 3));
            a = 8'($urandom);
            b = 8'($urandom);
            wr(4'h8, 32'(dv), t);
            rd_chk("div_rb", 4'h8, 32'(dv));
            xfer(a, b, dv);
        end
        // second DATA write while busy must be dropped
        wr(4'h8, 32'h3, t);
        so_byte = 8'h3C;
        base = rises;
        fb = falls;
        wr(4'h4, 32'hA5, t);
        wr(4'h4, 32'h5A, t);
        rd_chk("stat_dropped", 4'h0, 32'h0B);
        for (int i = 0; i < 1000 && falls - fb < 8; i++) @(negedge clk_48);
        repeat (4) @(negedge clk_48);
        chk("drop_rises", 32'(rises - base), 8);
        chk("drop_mosi", {24'h0, mosi_sh}, 32'hA5);
        rd_chk("drop_rx", 4'h4, 32'h3C);
        rd_chk("stat_sticky", 4'h0, 32'h09);
        wr(4'h0, 32'h1, t);
        rd_chk("stat_cleared", 4'h0, 32'h01);
`ifdef SPI_FLASH_CTRL_JTAG_EN
        wr(4'h0, 32'h0, t);
        chk("cs_released", 32'(flash_cs), 1);
        so_ovr_en = 1'b1;
        so_ovr = 1'b0;
        @(negedge clk_48);
        jtag_cs_n = 1'b0;
        repeat (2) @(negedge clk_48);
        chk("take_early", 32'(jtag_miso), 1);
        @(negedge clk_48);
        chk("take_miso", 32'(jtag_miso), 0);
        chk("take_cs", 32'(flash_cs), 0);
        jtag_clk = 1'b1;
        jtag_mosi = 1'b1;
        so_ovr = 1'b1;
        #1;
        chk("pass_clk_hi", 32'(flash_clk), 1);
        chk("pass_si_hi", 32'(flash_si), 1);
        chk("pass_miso_hi", 32'(jtag_miso), 1);
        jtag_clk = 1'b0;
        jtag_mosi = 1'b0;
        so_ovr = 1'b0;
        #1;
        chk("pass_clk_lo", 32'(flash_clk), 0);
        chk("pass_miso_lo", 32'(jtag_miso), 0);
        rd_chk("stat_owner", 4'h0, 32'h04);
        wr(4'h4, 32'h55, t);
        rd_chk("stat_owner_drop", 4'h0, 32'h0C);
        @(negedge clk_48);
        jtag_cs_n = 1'b1;
        repeat (2) @(negedge clk_48);
        chk("release_early", 32'(jtag_miso), 0);
        @(negedge clk_48);
        chk("release_miso", 32'(jtag_miso), 1);
        wr(4'h0, 32'h0, t);
        rd_chk("stat_idle", 4'h0, 32'h0);
        wr(4'h0, 32'h1, t);
        jtag_cs_n = 1'b0;
        jtag_clk = 1'b1;
        repeat (4) @(negedge clk_48);
        chk("deny_miso", 32'(jtag_miso), 1);
        chk("deny_cs", 32'(flash_cs), 0);
        chk("deny_sck", 32'(flash_clk), 0);
        rd_chk("stat_denied", 4'h0, 32'h11);
        jtag_cs_n = 1'b1;
        jtag_clk = 1'b0;
        repeat (3) @(negedge clk_48);
        wr(4'h0, 32'h1, t);
        rd_chk("stat_deny_clr", 4'h0, 32'h01);
        so_ovr_en = 1'b0;
`else
        wr(4'h0, 32'h0, t);
        so_ovr_en = 1'b1;
        so_ovr = 1'b0;
        jtag_cs_n = 1'b0;
        jtag_clk = 1'b1;
        jtag_mosi = 1'b1;
        repeat (5) @(negedge clk_48);
        chk("nojtag_miso", 32'(jtag_miso), 1);
        chk("nojtag_cs", 32'(flash_cs), 1);
        chk("nojtag_sck", 32'(flash_clk), 0);
        chk("nojtag_si", 32'(flash_si), 0);
        rd_chk("nojtag_stat", 4'h0, 32'h0);
        jtag_cs_n = 1'b1;
        jtag_clk = 1'b0;
        jtag_mosi = 1'b0;
        so_ovr_en = 1'b0;
        wr(4'h0, 32'h1, t);
`endif
        // async reset in the 6th half-period (SCK high, after two falls) of a DIV=3 byte
        wr(4'h8, 32'h3, t);
        so_byte = 8'h81;
        base = rises;
        wr(4'h4, 32'h24, t);
        repeat (20) @(negedge clk_48);
        chk("pre_rst_cs", 32'(flash_cs), 0);
        chk("pre_rst_sck", 32'(flash_clk), 1);
        chk("pre_rst_si", 32'(flash_si), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cs", 32'(flash_cs), 1);
        chk("arst_sck", 32'(flash_clk), 0);
        chk("arst_si", 32'(flash_si), 0);
        chk("arst_miso", 32'(jtag_miso), 1);
        chk("arst_ready", 32'(io.ready), 0);
        @(negedge clk_48);
        rst = 1'b0;
        rd_chk("stat_post_rst", 4'h0, 32'h0);
        rd_chk("div_post_rst", 4'h8, 32'h1);
        rd_chk("data_post_rst", 4'h4, 32'h0);
        chk("sck_post_rst", 32'(flash_clk), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
